// File: rtl/seq_serializer.sv
// -----------------------------------------------------------------------------
// seq_serializer
//
// Parallel-to-serial bit-stream source feeding the sequence detector's din.
// Words of 1..WIDTH bits arrive over a valid/ready handshake and leave one bit
// per clock on dout. A one-entry holding register lets back-to-back words
// stream with no idle cycle between them.
//
// Build option:
//   SER_LSB_FIRST_EN  defined   -> bits sent LSB-first (bit 0 .. bit len-1)
//                     undefined -> bits sent MSB-first (bit len-1 .. bit 0)
//
// Parameters:
//   WIDTH       maximum word length in bits
//   LEN_W       width of the length field (must be able to hold WIDTH)
//
// Ports:
//   clk         clock, rising edge
//   rst         synchronous active-high reset
//   in_valid    word offered on in_data/in_len
//   in_ready    block can take a word this cycle
//   in_data     payload, low in_len bits used
//   in_len      bit count; 0 drops the word, values above WIDTH clamp to WIDTH
//   dout        serial bit stream
//   dout_valid  dout carries a payload bit
//   word_done   last bit of a word is on dout this cycle
//   busy        shifter active or holding register occupied
// -----------------------------------------------------------------------------
module seq_serializer #(
   parameter int WIDTH = 16,
   parameter int LEN_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [LEN_W-1:0] in_len,
   output logic             dout,
   output logic             dout_valid,
   output logic             word_done,
   output logic             busy
);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state;
   logic [WIDTH-1:0] shreg;
   logic [LEN_W-1:0] cnt;
   logic [WIDTH-1:0] pend_data;
   logic [LEN_W-1:0] pend_len;
   logic             pend_valid;

   logic             active;
   logic             last_bit;
   logic             accept;
   logic [LEN_W-1:0] len_c;
   logic             len_zero;
   logic             head;

   // Clamp an oversize length request down to WIDTH.
   function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
      if (len > LEN_W'(WIDTH))
         return LEN_W'(WIDTH);
      return len;
   endfunction

   // Keep only the low len bits and place them so the first bit to be sent
   // sits at the shifter head (bit WIDTH-1 for MSB-first, bit 0 for LSB-first).
   // len is 1..WIDTH here; zero-length words never reach the shifter.
   function automatic logic [WIDTH-1:0] align_word(input logic [WIDTH-1:0] d,
                                                    input logic [LEN_W-1:0] len);
      logic [WIDTH-1:0] m;
      int               sh;
      sh = WIDTH - int'(len);
      m  = {WIDTH{1'b1}} >> sh;
`ifdef SER_LSB_FIRST_EN
      return d & m;
`else
      return (d & m) << sh;
`endif
   endfunction

   assign active   = (state == SHIFT);
   assign last_bit = active && (cnt == LEN_W'(1));
   assign in_ready = !pend_valid && !rst;
   assign accept   = in_valid && in_ready;
   assign len_c    = clamp_len(in_len);
   assign len_zero = (len_c == '0);

`ifdef SER_LSB_FIRST_EN
   assign head = shreg[0];
`else
   assign head = shreg[WIDTH-1];
`endif

   // All outputs come straight from state registers.
   assign dout       = active && head;
   assign dout_valid = active;
   assign word_done  = last_bit;
   assign busy       = active || pend_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         shreg      <= '0;
         cnt        <= '0;
         pend_valid <= 1'b0;
      end else begin
         if (!active || last_bit) begin
            // Shifter is free after this edge: refill it, held word first.
            // An accept cannot coincide with pend_valid since in_ready is low.
            if (last_bit && pend_valid) begin
               shreg      <= align_word(pend_data, pend_len);
               cnt        <= pend_len;
               state      <= SHIFT;
               pend_valid <= 1'b0;
            end else if (accept && !len_zero) begin
               shreg <= align_word(in_data, len_c);
               cnt   <= len_c;
               state <= SHIFT;
            end else begin
               state <= IDLE;
               cnt   <= '0;
            end
         end else begin
            // Mid-word: advance the shifter, park any new word.
`ifdef SER_LSB_FIRST_EN
            shreg <= shreg >> 1;
`else
            shreg <= shreg << 1;
`endif
            cnt <= cnt - LEN_W'(1);
            if (accept && !len_zero) begin
               pend_data  <= in_data;
               pend_len   <= len_c;
               pend_valid <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_seq_serializer.sv
module tb_seq_serializer;

   localparam int WIDTH = 16;
   localparam int LEN_W = 5;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic [LEN_W-1:0] in_len;
   logic             dout;
   logic             dout_valid;
   logic             word_done;
   logic             busy;

   int n_vec  = 0;
   int n_miss = 0;

   // stimulus word list for run()
   logic [WIDTH-1:0] w_data [8];
   logic [LEN_W-1:0] w_len  [8];
   int               nw;

   // results collected by run()
   logic [63:0] col;
   int          nbits, ndone, nlow, first, last, done_cyc;

`ifdef SER_LSB_FIRST_EN
   localparam logic [15:0] EXP_T1 = 16'hA2DB;
   localparam logic [11:0] EXP_T2 = 12'b1011_1101_0110;
   localparam logic [3:0]  EXP_T6 = 4'b1100;
`else
   localparam logic [15:0] EXP_T1 = 16'hDB45;
   localparam logic [11:0] EXP_T2 = 12'b1101_1011_0110;
   localparam logic [3:0]  EXP_T6 = 4'b0011;
`endif

   seq_serializer #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_len     (in_len),
      .dout       (dout),
      .dout_valid (dout_valid),
      .word_done  (word_done),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Drive the word list and record the serial output for ncyc cycles.
   // Called right after a falling edge; cycle index 0 is the cycle after the
   // first rising edge.
   task automatic run(input int ncyc);
      int  idx;
      logic xfer;
      idx = 0;
      col = '0; nbits = 0; ndone = 0; nlow = 0; first = -1; last = -1; done_cyc = -1;
      in_valid = (nw > 0);
      in_data  = w_data[0];
      in_len   = w_len[0];
      for (int c = 0; c < ncyc; c++) begin
         xfer = in_valid && in_ready;
         @(negedge clk);
         if (xfer) begin
            idx++;
            if (idx < nw) begin
               in_data = w_data[idx];
               in_len  = w_len[idx];
            end else begin
               in_valid = 1'b0;
            end
         end
         if (dout_valid) begin
            col = {col[62:0], dout};
            nbits++;
            if (first < 0) first = c;
            last = c;
         end
         if (word_done) begin
            ndone++;
            done_cyc = c;
         end
         if (!in_ready) nlow++;
      end
      in_valid = 1'b0;
   endtask

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;
      in_len   = '0;
      repeat (2) @(negedge clk);
      chk("rst_in_ready",   in_ready,   1'b0);
      chk("rst_busy",       busy,       1'b0);
      chk("rst_dout_valid", dout_valid, 1'b0);
      chk("rst_word_done",  word_done,  1'b0);
      chk("rst_dout",       dout,       1'b0);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", in_ready, 1'b1);

      // single 16-bit word
      w_data[0] = 16'hDB45; w_len[0] = 5'd16; nw = 1;
      run(18);
      chk("t1_bits",     col,      {48'd0, EXP_T1});
      chk("t1_nbits",    nbits,    16);
      chk("t1_first",    first,    0);
      chk("t1_last",     last,     15);
      chk("t1_ndone",    ndone,    1);
      chk("t1_done_cyc", done_cyc, 15);
      chk("t1_dout_idle", dout,    1'b0);
      chk("t1_busy_idle", busy,    1'b0);

      // three 4-bit words streamed through the holding register
      w_data[0] = 16'h000D; w_len[0] = 5'd4;
      w_data[1] = 16'h000B; w_len[1] = 5'd4;
      w_data[2] = 16'h0006; w_len[2] = 5'd4;
      nw = 3;
      run(14);
      chk("t2_bits",   col,                     {52'd0, EXP_T2});
      chk("t2_nbits",  nbits,                   12);
      chk("t2_nogap",  last - first + 1,        12);
      chk("t2_ndone",  ndone,                   3);
      chk("t2_nlow",   nlow,                    6);
      chk("t2_busy",   busy,                    1'b0);

      // zero-length word dropped, then 3-bit word
      w_data[0] = 16'hFFFF; w_len[0] = 5'd0;
      w_data[1] = 16'h0005; w_len[1] = 5'd3;
      nw = 2;
      run(8);
      chk("t3_bits",  col,   64'b101);
      chk("t3_nbits", nbits, 3);
      chk("t3_ndone", ndone, 1);
      chk("t3_first", first, 1);

      // oversize length clamps to WIDTH
      w_data[0] = 16'hFFFF; w_len[0] = 5'd20; nw = 1;
      run(20);
      chk("t4_bits",  col,   64'hFFFF);
      chk("t4_nbits", nbits, 16);
      chk("t4_ndone", ndone, 1);

      // reset mid-word with a word pending
      in_valid = 1'b1; in_data = 16'hAAAA; in_len = 5'd16;
      @(negedge clk);                         // bit 1 on dout
      in_data = 16'h000F; in_len = 5'd4;
      @(negedge clk);                         // bit 2; second word now held
      in_valid = 1'b0;
      chk("t5_pend_ready", in_ready, 1'b0);
      chk("t5_pend_busy",  busy,     1'b1);
      repeat (3) @(negedge clk);              // bit 5
      chk("t5_bit5_valid", dout_valid, 1'b1);
      rst = 1'b1;
      #1;
      chk("t5_rst_ready", in_ready, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("t5_dout_valid", dout_valid, 1'b0);
      chk("t5_busy",       busy,       1'b0);
      chk("t5_ready",      in_ready,   1'b1);
      chk("t5_dout",       dout,       1'b0);
      nw = 0;
      run(20);
      chk("t5_no_bits", nbits, 0);
      chk("t5_no_done", ndone, 0);

      // bit order check
      w_data[0] = 16'h0003; w_len[0] = 5'd4; nw = 1;
      run(6);
      chk("t6_bits",  col,   {60'd0, EXP_T6});
      chk("t6_nbits", nbits, 4);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/seq_serializer.md
# seq_serializer

Parallel-to-serial bit-stream source that feeds the sequence detector's `din` input. It accepts words of 1..`WIDTH` bits over a valid/ready handshake and emits them one bit per clock on `dout`. A one-entry holding register lets consecutive words stream with no idle gap between them.

## Interface
- `WIDTH`, default 16: maximum word length in bits.
- `LEN_W`, default 5: width of the length field; must hold the value `WIDTH`.
- `clk`  in  1: sole clock; all state updates on the rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `in_valid`  in  1: the word on `in_data`/`in_len` is offered.
- `in_ready`  out  1: the block can take a word this cycle.
- `in_data`  in  `WIDTH`: payload; the low `in_len` bits are used.
- `in_len`  in  `LEN_W`: number of bits to send; 0 means drop the word, values above `WIDTH` are clamped to `WIDTH`.
- `dout`  out  1: serial bit stream; connects to the detector's `din`.
- `dout_valid`  out  1: `dout` carries a payload bit this cycle.
- `word_done`  out  1: high during the cycle in which the last bit of a word is on `dout`.
- `busy`  out  1: shifter active or holding register occupied.

## Operation
- **State:** shifter (`shreg`, `cnt`, `active`) plus holding register (`pend_data`, `pend_len`, `pend_valid`).
- **FSM:** `IDLE` (`active`=0) and `SHIFT` (`active`=1). `pend_valid` is an orthogonal flag.
- **Handshake:**
  - `in_ready = !pend_valid && !rst`.
  - A transfer occurs when `in_valid && in_ready` at a clock edge.
  - `in_data` and `in_len` must hold stable while `in_valid` is high and `in_ready` is low.
- **Word routing on accept:**
  - Goes straight into the shifter if it is idle or finishing its last bit this edge.
  - Otherwise goes into the holding register.
- **Shifter load:**
  - `shreg` = low `len` bits of the payload, aligned so bit `len-1` is sent first.
  - `cnt` = `len`.
  - `active` = 1.
- **In `SHIFT`:**
  - `dout` = current head bit of `shreg`; `dout_valid` = 1.
  - Each edge shifts one bit and decrements `cnt`.
- **Last bit (`cnt`==1), priority at that edge:**
  1. Load the holding register into the shifter and clear `pend_valid`.
  2. Else load a word accepted this same edge.
  3. Else go to `IDLE`.
- **Zero-length words:** accepted, never loaded, and produce no `word_done`.
- **IDLE outputs:** `dout`=0, `dout_valid`=0.
- **`word_done`:** equals `active && cnt==1`.
- **`busy`:** equals `active || pend_valid`.
- **Reset:**
  - Clears `shreg`, `cnt`, `active` and `pend_valid`.
  - Outputs after reset: `dout`=0, `dout_valid`=0, `word_done`=0, `busy`=0, `in_ready`=0 while `rst` is high and 1 on the first cycle after it.
  - Reset mid-word discards the remaining bits and any pending word.

## Timing
- **Latency:** word accepted at edge N while idle → first bit on `dout` during cycle N+1.
- **Word length:** a word of length L occupies cycles N+1 .. N+L.
- **Back-to-back words:** the first bit of the next word appears in the cycle directly after the previous word's last bit, with no gap.
- **Throughput:** one bit per clock.
- **`in_ready` timing:**
  - Low from the edge that fills the holding register.
  - High again from the edge at which the held word moves into the shifter.
- **Outputs:** all derive from registers only; there is no combinational path from `in_*` to `dout`, `dout_valid` or `word_done`.

## Configuration
- **`SER_LSB_FIRST_EN`:**
  - Defined: bits are sent LSB-first, bit 0 through bit `len-1`.
  - Undefined (default): bits are sent MSB-first, bit `len-1` through bit 0.
  - Handshake, timing and `word_done` are identical in both builds.

## Test plan
- Reset, then offer `in_data`=16'hDB45, `in_len`=16 → from the next cycle, `dout` = 1,1,0,1,1,0,1,1,0,1,0,0,0,1,0,1 with `dout_valid`=1 for 16 cycles; `word_done` high on the 16th cycle only; `dout`=0 afterwards.
- Three words with `in_len`=4 (4'hD, 4'hB, 4'h6) offered with `in_valid` held high → 12 consecutive valid bits 1101 1011 0110 with no gap; `in_ready` drops while the holding register is full.
- `in_len`=0 accepted, then 16'h0005 with `in_len`=3 → only bits 1,0,1 appear; one `word_done` pulse total.
- `in_len`=20 with `in_data`=16'hFFFF → exactly 16 ones are sent.
- Assert `rst` for one cycle at bit 5 of a 16-bit word with a pending word queued → next cycle `dout_valid`=0 and `busy`=0; `in_ready`=0 during reset and 1 after; no further bits are emitted.
- Build with `SER_LSB_FIRST_EN`, send 4'b0011 with `in_len`=4 → `dout` = 1,1,0,0.
